// File: rtl/pool_relu_pkg.sv
// Shared geometry, addresses, FSM encoding and byte helpers for the pooling stage.
// No timing of its own; pure declarations and combinational helpers.
// Used by the top and the comparator sub-module.
package pool_relu_pkg;

    localparam logic [31:0] IN_BASE  = 32'h6000_0000;
    localparam logic [31:0] OUT_BASE = 32'h6000_4000;

    localparam int NCH           = 16;
    localparam int CH_W          = $clog2(NCH);
    localparam int IN_ROW_WORDS  = 8;
    localparam int OUT_ROW_WORDS = 4;
    localparam int OUT_ROWS      = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        DONE
    } state_t;

    // Input word index = ch*256 + row*8 + w, byte address = index*4.
    function automatic logic [31:0] rd_addr(input logic [CH_W-1:0] ch_i,
                                            input logic [4:0]      row_i,
                                            input logic [2:0]      w_i);
        return IN_BASE + (32'(ch_i) << 10) + (32'(row_i) << 5) + (32'(w_i) << 2);
    endfunction

    // Output word index = ch*64 + orow*4 + w.
    function automatic logic [31:0] wr_addr(input logic [CH_W-1:0] ch_i,
                                            input logic [3:0]      orow_i,
                                            input logic [1:0]      w_i);
        return OUT_BASE + (32'(ch_i) << 8) + (32'(orow_i) << 4) + (32'(w_i) << 2);
    endfunction

    function automatic logic [7:0] smax8(input logic signed [7:0] a,
                                         input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] relu8(input logic signed [7:0] a);
        return (a < 0) ? 8'h00 : a;
    endfunction

endpackage

// File: rtl/pool_relu_if.sv
// ICB command/response bundle between the pooling stage and the memory fabric.
// No latency; wires only.
// Command side is valid/ready; response side is accepted unconditionally by the master.
interface pool_relu_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/pool_max4.sv
// Horizontal pair max of a 4-pixel word, folded into the running vertical max.
// Combinational, zero latency.
// No flow control; evaluated whenever the parent accepts a response word.
module pool_max4
    import pool_relu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [7:0]  prev_lo,
    input  logic [7:0]  prev_hi,
    input  logic        first_row,
    output logic [7:0]  max_lo,
    output logic [7:0]  max_hi
);

    logic [7:0] pair_lo;
    logic [7:0] pair_hi;

    always_comb begin
        pair_lo = smax8(word[7:0],   word[15:8]);
        pair_hi = smax8(word[23:16], word[31:24]);
        // First row of the window seeds the buffer; the second row folds into it.
        max_lo  = first_row ? pair_lo : smax8(prev_lo, pair_lo);
        max_hi  = first_row ? pair_hi : smax8(prev_hi, pair_hi);
    end

endmodule

// File: rtl/pool_relu.sv
// 2x2/stride-2 signed max-pool of a 32x32x16 int8 map over ICB; optional ReLU under POOL_RELU_EN.
// One transaction in flight; next command issues the cycle after each response (5120 per run).
// Command held stable until cmd_ready; responses always accepted (rsp_ready tied high).
module pool_relu
    import pool_relu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    pool_relu_if.master pool_icb,
    input  logic        start,
    output logic        done
);

    state_t            state, state_nxt;
    logic [2:0]        w, w_nxt;
    logic [3:0]        orow, orow_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic              pend, pend_nxt;
    logic              start_q;
    logic              cmd_valid, cmd_valid_nxt;
    logic              cmd_read, cmd_read_nxt;
    logic [31:0]       cmd_addr, cmd_addr_nxt;
    logic [31:0]       cmd_wdata, cmd_wdata_nxt;
    logic              done_nxt;
    logic [15:0][7:0]  hm, hm_nxt;
    logic [7:0]        mx_lo, mx_hi;
    logic              cmd_fire, rsp_fire, start_rise;

    function automatic logic [7:0] out_byte(input logic [7:0] b);
`ifdef POOL_RELU_EN
        return relu8(b);
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] pack_word(input logic [15:0][7:0] row,
                                              input logic [1:0]       idx);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[8*k +: 8] = out_byte(row[{idx, 2'(k)}]);
        end
        return v;
    endfunction

    assign cmd_fire   = cmd_valid & pool_icb.cmd_ready;
    assign rsp_fire   = pend & pool_icb.rsp_valid;
    assign start_rise = start & ~start_q;

    pool_max4 u_max4 (
        .word      (pool_icb.rsp_rdata),
        .prev_lo   (hm[{w, 1'b0}]),
        .prev_hi   (hm[{w, 1'b1}]),
        .first_row (state == RD_A),
        .max_lo    (mx_lo),
        .max_hi    (mx_hi)
    );

    always_comb begin
        state_nxt     = state;
        w_nxt         = w;
        orow_nxt      = orow;
        ch_nxt        = ch;
        pend_nxt      = pend;
        cmd_valid_nxt = cmd_valid;
        cmd_read_nxt  = cmd_read;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        done_nxt      = done;
        hm_nxt        = hm;

        if (cmd_fire) begin
            cmd_valid_nxt = 1'b0;
            pend_nxt      = 1'b1;
        end
        if (rsp_fire) pend_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nxt     = RD_A;
                    done_nxt      = 1'b0;
                    w_nxt         = '0;
                    orow_nxt      = '0;
                    ch_nxt        = '0;
                    cmd_valid_nxt = 1'b1;
                    cmd_read_nxt  = 1'b1;
                    cmd_addr_nxt  = rd_addr('0, 5'd0, 3'd0);
                    cmd_wdata_nxt = '0;
                end
            end
            RD_A, RD_B: begin
                if (rsp_fire) begin
                    hm_nxt[{w, 1'b0}] = mx_lo;
                    hm_nxt[{w, 1'b1}] = mx_hi;
                    cmd_valid_nxt     = 1'b1;
                    cmd_wdata_nxt     = '0;
                    if (w != 3'd7) begin
                        w_nxt        = w + 3'd1;
                        cmd_read_nxt = 1'b1;
                        cmd_addr_nxt = rd_addr(ch, {orow, state == RD_B}, w + 3'd1);
                    end else if (state == RD_A) begin
                        w_nxt        = '0;
                        state_nxt    = RD_B;
                        cmd_read_nxt = 1'b1;
                        cmd_addr_nxt = rd_addr(ch, {orow, 1'b1}, 3'd0);
                    end else begin
                        // Last word of the odd row must be visible in the first write.
                        w_nxt         = '0;
                        state_nxt     = WR;
                        cmd_read_nxt  = 1'b0;
                        cmd_addr_nxt  = wr_addr(ch, orow, 2'd0);
                        cmd_wdata_nxt = pack_word(hm_nxt, 2'd0);
                    end
                end
            end
            WR: begin
                if (rsp_fire) begin
                    if (w != 3'd3) begin
                        w_nxt         = w + 3'd1;
                        cmd_valid_nxt = 1'b1;
                        cmd_read_nxt  = 1'b0;
                        cmd_addr_nxt  = wr_addr(ch, orow, w[1:0] + 2'd1);
                        cmd_wdata_nxt = pack_word(hm, w[1:0] + 2'd1);
                    end else begin
                        w_nxt = '0;
                        if (orow != 4'd15) begin
                            orow_nxt      = orow + 4'd1;
                            state_nxt     = RD_A;
                            cmd_valid_nxt = 1'b1;
                            cmd_read_nxt  = 1'b1;
                            cmd_addr_nxt  = rd_addr(ch, {orow + 4'd1, 1'b0}, 3'd0);
                            cmd_wdata_nxt = '0;
                        end else if (ch != CH_W'(NCH - 1)) begin
                            ch_nxt        = ch + CH_W'(1);
                            orow_nxt      = '0;
                            state_nxt     = RD_A;
                            cmd_valid_nxt = 1'b1;
                            cmd_read_nxt  = 1'b1;
                            cmd_addr_nxt  = rd_addr(ch + CH_W'(1), 5'd0, 3'd0);
                            cmd_wdata_nxt = '0;
                        end else begin
                            ch_nxt    = '0;
                            orow_nxt  = '0;
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_nxt      = 1'b1;
                state_nxt     = IDLE;
                cmd_read_nxt  = 1'b1;
                cmd_addr_nxt  = IN_BASE;
                cmd_wdata_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            w         <= '0;
            orow      <= '0;
            ch        <= '0;
            pend      <= 1'b0;
            start_q   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_read  <= 1'b1;
            cmd_addr  <= IN_BASE;
            cmd_wdata <= '0;
            done      <= 1'b0;
            hm        <= '0;
        end else begin
            state     <= state_nxt;
            w         <= w_nxt;
            orow      <= orow_nxt;
            ch        <= ch_nxt;
            pend      <= pend_nxt;
            start_q   <= start;
            cmd_valid <= cmd_valid_nxt;
            cmd_read  <= cmd_read_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            done      <= done_nxt;
            hm        <= hm_nxt;
        end
    end

    assign pool_icb.cmd_valid = cmd_valid;
    assign pool_icb.cmd_addr  = cmd_addr;
    assign pool_icb.cmd_read  = cmd_read;
    assign pool_icb.cmd_wdata = cmd_wdata;
    assign pool_icb.cmd_wmask = cmd_read ? 4'h0 : 4'hF;
    assign pool_icb.rsp_ready = 1'b1;

endmodule

// File: tb/tb_pool_relu.sv
// Bench for pool_relu: random-latency ICB memory slave, queue scoreboard of expected pooled writes.
// Expected writes come from a direct 2x2 window max over the source map.
module tb_pool_relu;
    import pool_relu_pkg::*;

    localparam int RUN_LIMIT = 40000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic done;

    pool_relu_if bus();

    pool_relu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pool_icb (bus),
        .start    (start),
        .done     (done)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [31:0] in_mem  [4096];
    logic [31:0] out_mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wcnt    = 0;
    int          rcnt    = 0;
    bit          arm_rst = 1'b0;
    bit          rst_trig = 1'b0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic signed [7:0] pix(input int c_i, input int y_i, input int x_i);
        logic [11:0] a;
        logic [31:0] wd;
        a  = 12'(c_i * 256 + y_i * 8 + x_i / 4);
        wd = in_mem[a];
        return wd[8 * (x_i % 4) +: 8];
    endfunction

    // Reference: each output byte is the max of its 2x2 source window.
    task automatic push_expected();
        wr_t e;
        int  m, p, col;
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 16; r++)
                for (int ow = 0; ow < 4; ow++) begin
                    e.addr = OUT_BASE + 32'((c * 64 + r * 4 + ow) * 4);
                    e.data = '0;
                    for (int k = 0; k < 4; k++) begin
                        col = 4 * ow + k;
                        m   = -128;
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                p = int'(pix(c, 2 * r + dy, 2 * col + dx));
                                if (p > m) m = p;
                            end
`ifdef POOL_RELU_EN
                        if (m < 0) m = 0;
`endif
                        e.data[8 * k +: 8] = 8'(m);
                    end
                    exp_q.push_back(e);
                end
    endtask

    task automatic check_reset_vals(input string tag);
        chk_eq({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        chk_eq({tag, "_cmd_read"},  32'(bus.cmd_read),  32'd1);
        chk_eq({tag, "_cmd_addr"},  bus.cmd_addr,       IN_BASE);
        chk_eq({tag, "_cmd_wdata"}, bus.cmd_wdata,      32'd0);
        chk_eq({tag, "_cmd_wmask"}, 32'(bus.cmd_wmask), 32'd0);
        chk_eq({tag, "_done"},      32'(done),          32'd0);
    endtask

    // Memory slave: random ready/response latency, spurious idle responses.
    initial begin : slave
        int          rdy_dly, rsp_dly;
        bit          waiting, outst, was_out, stall, in_rng;
        logic [31:0] rsp_dat, s_addr, s_wdata, idx;
        logic        s_read;
        wr_t         o;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        rdy_dly = 0; rsp_dly = 0;
        waiting = 0; outst = 0; stall = 0;
        rsp_dat = '0; s_addr = '0; s_wdata = '0; s_read = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outst = 0; waiting = 0; stall = 0;
                bus.cmd_ready = 1'b0;
                bus.rsp_valid = 1'b0;
                continue;
            end
            was_out = outst;
            bus.rsp_valid = 1'b0;
            if (outst) begin
                if (rsp_dly == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = rsp_dat;
                    outst = 0;
                end else rsp_dly--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = $urandom;
            end

            if (bus.cmd_valid) begin
                chk_eq("single_outstanding", 32'(was_out), 32'd0);
                if (stall) begin
                    chk_eq("stall_addr_stable",  bus.cmd_addr,       s_addr);
                    chk_eq("stall_read_stable",  32'(bus.cmd_read),  32'(s_read));
                    chk_eq("stall_wdata_stable", bus.cmd_wdata,      s_wdata);
                end
                if (!waiting) begin
                    waiting = 1;
                    rdy_dly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
                end
                if (rdy_dly == 0) begin
                    bus.cmd_ready = 1'b1;
                    waiting = 0;
                    stall   = 0;
                    outst   = 1;
                    rsp_dly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
                    if (bus.cmd_read) begin
                        idx    = (bus.cmd_addr - IN_BASE) >> 2;
                        in_rng = (bus.cmd_addr >= IN_BASE) && (idx < 32'd4096) && (bus.cmd_addr[1:0] == 2'b00);
                        chk_eq("rd_addr_in_range", 32'(in_rng), 32'd1);
                        chk_eq("rd_wmask", 32'(bus.cmd_wmask), 32'h0);
                        rsp_dat = in_rng ? in_mem[idx[11:0]] : 32'h0;
                        rcnt++;
                        if (arm_rst && idx[11:8] == 4'd3 && idx[3]) rst_trig = 1'b1;
                    end else begin
                        idx    = (bus.cmd_addr - OUT_BASE) >> 2;
                        in_rng = (bus.cmd_addr >= OUT_BASE) && (idx < 32'd1024) && (bus.cmd_addr[1:0] == 2'b00);
                        chk_eq("wr_addr_in_range", 32'(in_rng), 32'd1);
                        chk_eq("wr_wmask", 32'(bus.cmd_wmask), 32'hF);
                        if (in_rng) out_mem[idx[9:0]] = bus.cmd_wdata;
                        o.addr = bus.cmd_addr;
                        o.data = bus.cmd_wdata;
                        obs_q.push_back(o);
                        wcnt++;
                        rsp_dat = $urandom;
                    end
                end else begin
                    bus.cmd_ready = 1'b0;
                    rdy_dly--;
                    stall   = 1;
                    s_addr  = bus.cmd_addr;
                    s_read  = bus.cmd_read;
                    s_wdata = bus.cmd_wdata;
                end
            end else begin
                if (stall) chk_eq("valid_held_until_ready", 32'(bus.cmd_valid), 32'd1);
                stall   = 0;
                waiting = 0;
                bus.cmd_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard monitor: each observed write is matched against the next expected one.
    initial begin : monitor
        wr_t o, e;
        forever begin
            @(posedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                chk_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_eq("write_addr", o.addr, e.addr);
                    chk_eq("write_data", o.data, e.data);
                end
            end
        end
    end

    task automatic run_map(input bit do_toggle, input bit do_reset);
        int cyc;
        bit toggled;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 1024; i++) out_mem[i] = 32'hDEAD_BEEF;
        push_expected();
        wcnt = 0; rcnt = 0;
        rst_trig = 1'b0;
        arm_rst  = do_reset;
        toggled  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk_eq("start_clears_done",  32'(done),          32'd0);
        chk_eq("start_cmd_valid",    32'(bus.cmd_valid), 32'd1);
        chk_eq("start_first_addr",   bus.cmd_addr,       IN_BASE);
        chk_eq("start_first_read",   32'(bus.cmd_read),  32'd1);
        cyc = 0;
        while (!done && cyc < RUN_LIMIT && !(do_reset && rst_trig)) begin
            @(negedge clk);
            cyc++;
            if (do_toggle && !toggled && wcnt > 0) begin
                start = 1'b0;
                @(negedge clk);
                start = 1'b1;
                toggled = 1'b1;
                cyc++;
            end
        end
        if (do_reset) begin
            chk_eq("reset_trigger_seen", 32'(rst_trig), 32'd1);
            #3;
            rst_n = 1'b0;
            #1;
            check_reset_vals("midrun_reset");
            repeat (3) @(negedge clk);
            start = 1'b0;
            rst_n = 1'b1;
            arm_rst = 1'b0;
            @(negedge clk);
            exp_q.delete();
            obs_q.delete();
        end else begin
            chk_eq("run_in_budget", 32'(cyc < RUN_LIMIT), 32'd1);
            if (do_toggle) chk_eq("start_toggled_in_wr", 32'(toggled), 32'd1);
            repeat (2) @(negedge clk);
            chk_eq("write_count",    32'(wcnt),         32'd1024);
            chk_eq("read_count",     32'(rcnt),         32'd4096);
            chk_eq("expected_drain", 32'(exp_q.size()), 32'd0);
            chk_eq("done_set",       32'(done),         32'd1);
        end
    endtask

    initial begin : main
        logic [31:0] wd;
        int          rc, rr, rcol, exp_v;
        rst_n = 1'b1;
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp map: bottom-right pixel of every window is the largest.
        for (int i = 0; i < 4096; i++)
            for (int k = 0; k < 4; k++) in_mem[i][8 * k +: 8] = 8'((4 * i + k) % 128);
        run_map(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rc    = int'($urandom_range(0, 15));
            rr    = int'($urandom_range(0, 15));
            rcol  = int'($urandom_range(0, 15));
            exp_v = (rc * 1024 + (2 * rr + 1) * 32 + 2 * rcol + 1) % 128;
            wd    = out_mem[10'(rc * 64 + rr * 4 + rcol / 4)];
            chk_eq("ramp_bottom_right", 32'(wd[8 * (rcol % 4) +: 8]), 32'(exp_v));
        end
        repeat (5) @(negedge clk);
        chk_eq("done_sticky", 32'(done), 32'd1);

        // Second start rise reruns the same map.
        run_map(1'b0, 1'b0);

        // Random map with hand-placed signed corner cases.
        for (int i = 0; i < 4096; i++) in_mem[i] = $urandom;
        in_mem[0]   = 32'h807F_01FF;
        in_mem[8]   = 32'h0506_F0F1;
        in_mem[256] = {in_mem[256][31:16], 8'hF9, 8'hFD};
        in_mem[264] = {in_mem[264][31:16], 8'hF7, 8'hFE};
        run_map(1'b0, 1'b1);
        run_map(1'b0, 1'b0);

        wd = out_mem[0];
        chk_eq("mixed_sign_byte0", 32'(wd[7:0]),  32'h01);
        chk_eq("mixed_sign_byte1", 32'(wd[15:8]), 32'h7F);
        wd = out_mem[64];
`ifdef POOL_RELU_EN
        chk_eq("all_negative_block", 32'(wd[7:0]), 32'h00);
`else
        chk_eq("all_negative_block", 32'(wd[7:0]), 32'hFE);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
